// File: rtl/grf_pkg.sv
// grf_pkg: shared widths, zero-register index and register data type for the register file
package grf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG = 0;
  localparam int NUM_REGS = 32;
  typedef logic [DEF_DATA_W-1:0] reg_t;
endpackage

// File: rtl/grf_read_port.sv
// grf_read_port: zero-register masking and, with GRF_BYPASS_EN, same-cycle write bypass
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
`ifdef GRF_BYPASS_EN
  input  logic              commit,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
`endif
  output logic [DATA_W-1:0] rd
);
  logic is_zero;
  assign is_zero = addr == ADDR_W'(ZERO_REG);
`ifdef GRF_BYPASS_EN
  assign rd = is_zero ? '0 : (commit && addr == wa) ? wd : stored;
`else
  assign rd = is_zero ? '0 : stored;
`endif
endmodule

// File: rtl/grf.sv
// grf: 2^ADDR_W x DATA_W register file, r0 hard-wired to zero, commit counter; GRF_BYPASS_EN adds read bypass
module grf
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [CNT_W-1:0]  WriteCnt
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic commit;
  assign commit = WE && A3 != ADDR_W'(ZERO_REG);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      WriteCnt <= '0;
    end else if (commit) begin
      regs[A3] <= WD;
      WriteCnt <= WriteCnt + CNT_W'(1);
    end
  end
  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
    .addr(A1),
    .stored(regs[A1]),
`ifdef GRF_BYPASS_EN
    .commit(commit),
    .wa(A3),
    .wd(WD),
`endif
    .rd(RD1)
  );
  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
    .addr(A2),
    .stored(regs[A2]),
`ifdef GRF_BYPASS_EN
    .commit(commit),
    .wa(A3),
    .wd(WD),
`endif
    .rd(RD2)
  );
endmodule
